// File: rtl/rsa_req_arbiter_if.sv
// rsa_req_arbiter_if: requester-side and engine-side signals of the two-port modexp arbiter.
// slave is the arbiter's view; master is the requesters plus the engine.
interface rsa_req_arbiter_if;
  logic        req0;
  logic        req1;
  logic [31:0] base0;
  logic [31:0] exp0;
  logic [31:0] mod0;
  logic [31:0] base1;
  logic [31:0] exp1;
  logic [31:0] mod1;
  logic        done0;
  logic        done1;
  logic        err0;
  logic        err1;
  logic [31:0] res0;
  logic [31:0] res1;
  logic        eng_start;
  logic [31:0] eng_base;
  logic [31:0] eng_exp;
  logic [31:0] eng_mod;
  logic        eng_end;
  logic [31:0] eng_out;

  modport slave (
    input  req0, req1, base0, exp0, mod0, base1, exp1, mod1, eng_end, eng_out,
    output done0, done1, err0, err1, res0, res1, eng_start, eng_base, eng_exp, eng_mod
  );

  modport master (
    output req0, req1, base0, exp0, mod0, base1, exp1, mod1, eng_end, eng_out,
    input  done0, done1, err0, err1, res0, res1, eng_start, eng_base, eng_exp, eng_mod
  );
endinterface

// File: rtl/rsa_req_arbiter.sv
// rsa_req_arbiter: round-robin arbiter sharing one modular-exponentiation engine between two
// requesters. Define RSA_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles.
module rsa_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rstn,
  rsa_req_arbiter_if.slave bus,
  output logic             busy,
  output logic             owner
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e      r_state, w_state_d;
  logic        r_owner, r_last, r_err;
  logic [31:0] r_base, r_exp, r_mod, r_res0, r_res1;
  logic        w_any_req, w_grant, w_timeout, w_done0, w_done1;
  logic [31:0] w_sel_base, w_sel_exp, w_sel_mod;

  assign w_any_req  = bus.req0 | bus.req1;
  // Contention goes to whoever was not served last; a lone request wins outright.
  assign w_grant    = (bus.req0 & bus.req1) ? ~r_last : ~bus.req0;
  assign w_sel_base = w_grant ? bus.base1 : bus.base0;
  assign w_sel_exp  = w_grant ? bus.exp1  : bus.exp0;
  assign w_sel_mod  = w_grant ? bus.mod1  : bus.mod0;

`ifdef RSA_ARB_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;

  // Zero outside WAIT, so it is already clear on every entry to WAIT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tmo_cnt <= '0;
    end else if (r_state == StWait) begin
      r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == StWait) && !bus.eng_end &&
                     (r_tmo_cnt == TIMEOUT_CYCLES - 32'd1);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_any_req) w_state_d = (w_sel_mod == '0) ? StDone : StStart;
      StStart: w_state_d = StWait;
      StWait:  if (bus.eng_end || w_timeout) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_err   <= 1'b0;
      r_base  <= '0;
      r_exp   <= '0;
      r_mod   <= '0;
      r_res0  <= '0;
      r_res1  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_owner <= w_grant;
            r_base  <= w_sel_base;
            r_exp   <= w_sel_exp;
            r_mod   <= w_sel_mod;
            r_err   <= (w_sel_mod == '0);
            // Zero modulus never reaches the engine; its result is defined as 0.
            if (w_sel_mod == '0) begin
              if (w_grant) r_res1 <= '0;
              else         r_res0 <= '0;
            end
          end
        end
        StWait: begin
          if (bus.eng_end || w_timeout) begin
            if (r_owner) r_res1 <= bus.eng_end ? bus.eng_out : '0;
            else         r_res0 <= bus.eng_end ? bus.eng_out : '0;
            r_err <= w_timeout;
          end
        end
        StDone:  r_last <= r_owner;
        default: ;
      endcase
    end
  end

  assign w_done0 = (r_state == StDone) & ~r_owner;
  assign w_done1 = (r_state == StDone) & r_owner;

  assign busy          = (r_state != StIdle);
  assign owner         = r_owner;
  assign bus.eng_start = (r_state == StStart);
  assign bus.eng_base  = r_base;
  assign bus.eng_exp   = r_exp;
  assign bus.eng_mod   = r_mod;
  assign bus.done0     = w_done0;
  assign bus.done1     = w_done1;
  assign bus.err0      = w_done0 & r_err;
  assign bus.err1      = w_done1 & r_err;
  assign bus.res0      = r_res0;
  assign bus.res1      = r_res1;

endmodule

// File: tb/tb_rsa_req_arbiter.sv
// tb_rsa_req_arbiter: directed and randomized checks of rsa_req_arbiter against a behavioural
// model (modexp by square-and-multiply, round-robin order from the last-served requester).
module tb_rsa_req_arbiter;
  localparam int unsigned TmoCycles = 16;

  logic clk;
  logic rstn;
  logic busy;
  logic owner;

  rsa_req_arbiter_if bus ();

  rsa_req_arbiter #(.TIMEOUT_CYCLES(TmoCycles)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_start = 0;
  bit          eng_on = 1'b1;
  bit          stray_end = 1'b0;
  int          eng_lat_fix = 0;
  int          m_last;
  logic [31:0] m_res [2];

  function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                         input logic [31:0] m);
    logic [63:0] r, x;
    if (m == 0) return '0;
    r = 64'd1 % {32'd0, m};
    x = {32'd0, b} % {32'd0, m};
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % {32'd0, m};
      x = (x * x) % {32'd0, m};
    end
    return r[31:0];
  endfunction

  function automatic logic [31:0] pick_mod(input bit allow_zero);
    if (allow_zero && $urandom_range(0, 3) == 0) return '0;
    return $urandom | 32'h1;
  endfunction

  // Engine model: answers each start after a short latency with the true modexp result.
  initial begin
    int          eng_cd;
    logic [31:0] eng_res;
    eng_cd      = 0;
    eng_res     = '0;
    bus.eng_end = 1'b0;
    bus.eng_out = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.eng_end = 1'b0;
      if (eng_cd > 0) begin
        eng_cd--;
        if (eng_cd == 0) begin
          bus.eng_end = 1'b1;
          bus.eng_out = eng_res;
        end
      end else if (stray_end) begin
        bus.eng_end = 1'b1;
        bus.eng_out = 32'hA5A5_5A5A;
      end
      if (bus.eng_start) begin
        n_start++;
        if (eng_on) begin
          eng_res = modexp(bus.eng_base, bus.eng_exp, bus.eng_mod);
          eng_cd  = (eng_lat_fix != 0) ? eng_lat_fix : int'($urandom_range(1, 4));
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: observed no finish, expected finish within 500us");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checkb({tag, "_busy"}, busy, 1'b0);
    checkb({tag, "_owner"}, owner, 1'b0);
    checkb({tag, "_start"}, bus.eng_start, 1'b0);
    checkb({tag, "_done0"}, bus.done0, 1'b0);
    checkb({tag, "_done1"}, bus.done1, 1'b0);
    checkb({tag, "_err0"}, bus.err0, 1'b0);
    checkb({tag, "_err1"}, bus.err1, 1'b0);
    check({tag, "_res0"}, bus.res0, 32'h0);
    check({tag, "_res1"}, bus.res1, 32'h0);
    check({tag, "_eng_base"}, bus.eng_base, 32'h0);
    check({tag, "_eng_exp"}, bus.eng_exp, 32'h0);
    check({tag, "_eng_mod"}, bus.eng_mod, 32'h0);
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
    tick();
    rstn      = 1'b1;
    m_last    = 1;
    m_res[0]  = '0;
    m_res[1]  = '0;
    tick();
  endtask

  task automatic rand_ops(input bit allow_zero);
    bus.base0 = $urandom;
    bus.exp0  = $urandom;
    bus.mod0  = pick_mod(allow_zero);
    bus.base1 = $urandom;
    bus.exp1  = $urandom;
    bus.mod1  = pick_mod(allow_zero);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 8 && !ok; c++) begin
      tick();
      if (bus.eng_start) ok = 1'b1;
    end
    n_tests++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL start_wait: observed no eng_start in 8 cycles, expected one");
    end
  endtask

  // Waits for the next done and checks it belongs to 'who' with the model's result.
  task automatic serve_expect(input int who, input bit drop);
    logic [31:0] b, e, m, er;
    logic        eerr;
    bit          seen;
    b    = who ? bus.base1 : bus.base0;
    e    = who ? bus.exp1  : bus.exp0;
    m    = who ? bus.mod1  : bus.mod0;
    eerr = (m == 0);
    er   = modexp(b, e, m);
    seen = 1'b0;
    for (int c = 0; c < 64 && !seen; c++) begin
      tick();
      if (bus.done0 || bus.done1) begin
        seen = 1'b1;
        check("done_onehot", 32'({bus.done1, bus.done0}), 32'(1 << who));
        check("owner", 32'(owner), 32'(who));
        checkb("err", who ? bus.err1 : bus.err0, eerr);
        check("res", who ? bus.res1 : bus.res0, er);
        check("other_res", who ? bus.res0 : bus.res1, m_res[1-who]);
        m_res[who] = er;
        m_last     = who;
        if (drop) begin
          if (who != 0) bus.req1 = 1'b0;
          else          bus.req0 = 1'b0;
        end
      end
    end
    n_tests++;
    assert (seen) else begin
      n_fail++;
      $error("FAIL done_wait: observed no done in 64 cycles, expected done%0d", who);
    end
  endtask

  initial begin
    bit         ok;
    int         s0;
    int         nz;
    int         first;
    int         bad;
    logic [1:0] pat;

    rstn     = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    rand_ops(1'b0);
    do_reset();
    check_reset_vals("rst");

    // Single request with the reference vector; start one cycle after sampling.
    bus.base0 = 32'h032178C4;
    bus.exp0  = 32'h00000011;
    bus.mod0  = 32'h07A50679;
    s0        = n_start;
    bus.req0  = 1'b1;
    tick();
    checkb("lat_start", bus.eng_start, 1'b1);
    checkb("busy_start", busy, 1'b1);
    check("eng_base", bus.eng_base, 32'h032178C4);
    check("eng_mod", bus.eng_mod, 32'h07A50679);
    tick();
    checkb("start_one_cycle", bus.eng_start, 1'b0);
    serve_expect(0, 1'b1);
    tick();
    check("single_start_count", n_start - s0, 1);
    checkb("idle_after_done", busy, 1'b0);

    // Zero modulus bypasses the engine.
    bus.base1 = $urandom;
    bus.mod1  = '0;
    s0        = n_start;
    bus.req1  = 1'b1;
    tick();
    checkb("mod0_done1", bus.done1, 1'b1);
    checkb("mod0_err1", bus.err1, 1'b1);
    check("mod0_res1", bus.res1, 32'h0);
    checkb("mod0_done0", bus.done0, 1'b0);
    check("mod0_res0_kept", bus.res0, m_res[0]);
    bus.req1 = 1'b0;
    m_res[1] = '0;
    m_last   = 1;
    tick();
    checkb("mod0_idle", busy, 1'b0);
    check("mod0_no_start", n_start - s0, 0);

    // Stray engine completion while idle.
    stray_end = 1'b1;
    tick();
    stray_end = 1'b0;
    checkb("stray_busy_a", busy, 1'b0);
    tick();
    checkb("stray_busy_b", busy, 1'b0);
    checkb("stray_done", bus.done0 | bus.done1, 1'b0);
    check("stray_res0", bus.res0, m_res[0]);

    // req0 held; req1 arrives during requester 0's WAIT and wins the next grant.
    rand_ops(1'b0);
    bus.req0 = 1'b1;
    wait_start(ok);
    tick();
    bus.req1 = 1'b1;
    serve_expect(0, 1'b0);
    serve_expect(1, 1'b1);
    serve_expect(0, 1'b1);
    tick();

    // Randomized request patterns against the model.
    for (int t = 0; t < 16; t++) begin
      pat = 2'($urandom_range(1, 3));
      rand_ops(1'b1);
      nz = 0;
      if (pat[0] && bus.mod0 != 0) nz++;
      if (pat[1] && bus.mod1 != 0) nz++;
      s0       = n_start;
      bus.req0 = pat[0];
      bus.req1 = pat[1];
      if (pat == 2'b11) begin
        first = 1 - m_last;
        serve_expect(first, 1'b1);
        serve_expect(1 - first, 1'b1);
      end else begin
        serve_expect(pat[1] ? 1 : 0, 1'b1);
      end
      tick();
      check("rand_start_count", n_start - s0, nz);
      checkb("rand_idle", busy, 1'b0);
    end

    // Simultaneous requests straight after reset: 0 then 1.
    do_reset();
    rand_ops(1'b0);
    s0       = n_start;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    serve_expect(0, 1'b1);
    serve_expect(1, 1'b1);
    tick();
    check("both_start_count", n_start - s0, 2);

    // Reset during WAIT discards the operation; the late eng_end is ignored.
    eng_lat_fix = 8;
    rand_ops(1'b0);
    bus.req0 = 1'b1;
    wait_start(ok);
    tick();
    checkb("wait_busy", busy, 1'b1);
    rstn = 1'b0;
    #1;
    check_reset_vals("async_rst");
    bus.req0 = 1'b0;
    m_res[0] = '0;
    m_res[1] = '0;
    m_last   = 1;
    tick();
    tick();
    rstn = 1'b1;
    bad  = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.done0 || bus.done1 || busy) bad++;
    end
    check("no_done_after_rst", bad, 0);
    check_reset_vals("post_rst");
    eng_lat_fix = 0;

`ifdef RSA_ARB_TIMEOUT_EN
    // Engine never answers: abort after TmoCycles WAIT cycles.
    eng_on   = 1'b0;
    rand_ops(1'b0);
    bus.req0 = 1'b1;
    wait_start(ok);
    bad = 0;
    for (int c = 0; c < 100 && !bus.done0; c++) begin
      tick();
      if (!bus.done0) bad++;
    end
    check("tmo_wait_cycles", bad, TmoCycles);
    checkb("tmo_done0", bus.done0, 1'b1);
    checkb("tmo_err0", bus.err0, 1'b1);
    check("tmo_res0", bus.res0, 32'h0);
    bus.req0 = 1'b0;
    tick();
    checkb("tmo_idle", busy, 1'b0);
    eng_on = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
